// File: rtl/hamming_74_secded_dec.sv
// SECDED(8,4) receive decoder: Hamming(7,4) code word plus overall parity.
// Two-stage valid/ready pipeline with saturating error event counters.
`timescale 1ns/1ps

module hamming_74_secded_dec #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    input  logic             in_parity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic             out_corrected,
    output logic             out_uncorrectable,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] uncorr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid_q, s1_valid_d;
    logic [6:0]       s1_code_q,  s1_code_d;
    logic [2:0]       s1_syn_q,   s1_syn_d;
    logic             s1_pe_q,    s1_pe_d;

    logic             s2_valid_q, s2_valid_d;
    logic [3:0]       s2_data_q,  s2_data_d;
    logic [2:0]       s2_syn_q,   s2_syn_d;
    logic             s2_corr_q,  s2_corr_d;
    logic             s2_unc_q,   s2_unc_d;

    logic [CNT_W-1:0] corr_cnt_q,   corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

    logic             s1_load;
    logic             s2_load;
    logic             out_hs;
    logic [6:0]       flip_mask;
    logic [6:0]       fixed_code;
    logic             syn_nz;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;
    assign out_hs   = s2_valid_q && out_ready;

    // Stage 1: capture the word together with its syndrome and parity check.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
        s1_pe_d    = s1_pe_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_code_d   = in_code;
                s1_syn_d[0] = in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6];
                s1_syn_d[1] = in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6];
                s1_syn_d[2] = in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6];
                s1_pe_d     = (^in_code) ^ in_parity;
            end
        end
    end

    // Syndrome value n points at code position n, i.e. code bit n-1.
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            flip_mask[i] = (s1_syn_q == 3'(i + 1));
        end
    end

    assign syn_nz     = (s1_syn_q != 3'd0);
    assign fixed_code = (syn_nz && s1_pe_q) ? (s1_code_q ^ flip_mask) : s1_code_q;

    // Stage 2: classify and extract data; a double error passes data uncorrected.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_syn_d   = s2_syn_q;
        s2_corr_d  = s2_corr_q;
        s2_unc_d   = s2_unc_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
                s2_syn_d  = s1_syn_q;
                s2_corr_d = s1_pe_q;
                s2_unc_d  = syn_nz && !s1_pe_q;
            end
        end
    end

    // Counters count delivered words only; a clear beats a same-cycle increment.
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (cnt_clear) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_hs) begin
            if (s2_corr_q && (corr_cnt_q != CNT_MAX)) begin
                corr_cnt_d = corr_cnt_q + CNT_ONE;
            end
            if (s2_unc_q && (uncorr_cnt_q != CNT_MAX)) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= '0;
            s1_syn_q     <= '0;
            s1_pe_q      <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_syn_q     <= '0;
            s2_corr_q    <= 1'b0;
            s2_unc_q     <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_code_q    <= s1_code_d;
            s1_syn_q     <= s1_syn_d;
            s1_pe_q      <= s1_pe_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_syn_q     <= s2_syn_d;
            s2_corr_q    <= s2_corr_d;
            s2_unc_q     <= s2_unc_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid         = s2_valid_q;
    assign out_data          = s2_data_q;
    assign out_syndrome      = s2_syn_q;
    assign out_corrected     = s2_corr_q;
    assign out_uncorrectable = s2_unc_q;
    assign corr_count        = corr_cnt_q;
    assign uncorr_count      = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_74_secded_dec.sv
// Directed bench for hamming_74_secded_dec: vector table, backpressure stream,
// counter clear/saturation (second instance with CNT_W=2) and async reset.
`timescale 1ns/1ps

module tb_hamming_74_secded_dec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [6:0]  in_code = '0;
    logic        in_parity = 1'b0;
    logic        out_ready = 1'b1;
    logic        cnt_clear = 1'b0;

    logic        in_ready, out_valid, out_corrected, out_uncorrectable;
    logic [3:0]  out_data;
    logic [2:0]  out_syndrome;
    logic [15:0] corr_count, uncorr_count;

    logic        sm_in_ready, sm_out_valid, sm_out_corrected, sm_out_uncorrectable;
    logic [3:0]  sm_out_data;
    logic [2:0]  sm_out_syndrome;
    logic [1:0]  sm_corr_count, sm_uncorr_count;

    int checks = 0;
    int failures = 0;
    int exp_corr = 0, exp_unc = 0, exp_corr_s = 0, exp_unc_s = 0;

    typedef struct {
        logic [6:0] code;
        logic       parity;
        logic [3:0] data;
        logic [2:0] syn;
        logic       corr;
        logic       unc;
    } vec_t;

    vec_t vecs[10];

    hamming_74_secded_dec #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_parity(in_parity),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_syndrome(out_syndrome),
        .out_corrected(out_corrected), .out_uncorrectable(out_uncorrectable),
        .cnt_clear(cnt_clear),
        .corr_count(corr_count), .uncorr_count(uncorr_count)
    );

    hamming_74_secded_dec #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(sm_in_ready),
        .in_code(in_code), .in_parity(in_parity),
        .out_valid(sm_out_valid), .out_ready(out_ready),
        .out_data(sm_out_data), .out_syndrome(sm_out_syndrome),
        .out_corrected(sm_out_corrected), .out_uncorrectable(sm_out_uncorrectable),
        .cnt_clear(cnt_clear),
        .corr_count(sm_corr_count), .uncorr_count(sm_uncorr_count)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    task automatic checkCounters(input string tag);
        checkVal({tag, "_corr16"},  32'(corr_count),      32'(exp_corr));
        checkVal({tag, "_unc16"},   32'(uncorr_count),    32'(exp_unc));
        checkVal({tag, "_corr2"},   32'(sm_corr_count),   32'(exp_corr_s));
        checkVal({tag, "_unc2"},    32'(sm_uncorr_count), 32'(exp_unc_s));
    endtask

    // Sends one word into an empty pipeline; returns negedges until out_valid.
    task automatic applyStimulus(input logic [6:0] code, input logic parity, output int lat);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = code;
        in_parity = parity;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Compares the presented word, lets it be consumed, then checks counters.
    task automatic checkOutput(input vec_t v, input string tag);
        checkVal({tag, "_data"}, 32'(out_data),          32'(v.data));
        checkVal({tag, "_syn"},  32'(out_syndrome),      32'(v.syn));
        checkVal({tag, "_corr"}, 32'(out_corrected),     32'(v.corr));
        checkVal({tag, "_unc"},  32'(out_uncorrectable), 32'(v.unc));
        if (v.corr) begin
            exp_corr++;
            if (exp_corr_s < 3) exp_corr_s++;
        end
        if (v.unc) begin
            exp_unc++;
            if (exp_unc_s < 3) exp_unc_s++;
        end
        @(posedge clk);
        @(negedge clk);
        checkVal({tag, "_drained"}, 32'(out_valid), 32'd0);
        checkCounters(tag);
    endtask

    task automatic runVector(input vec_t v, input string tag);
        int lat;
        applyStimulus(v.code, v.parity, lat);
        checkVal({tag, "_latency"}, 32'(lat), 32'd2);
        if (lat < 10) checkOutput(v, tag);
    endtask

    task automatic runBackpressure();
        logic [3:0] exp_q[$];
        logic [3:0] d;
        logic [3:0] held_data;
        logic [2:0] held_syn;
        logic       pattern [4];
        bit held = 0, saw_full = 0, in_hs, out_hs;
        int sent = 0, got = 0, cyc = 0;
        pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b0; pattern[3] = 1'b1;
        while (got < 8 && cyc < 200) begin
            @(negedge clk);
            if (held) begin
                checkVal("bp_stall_valid", 32'(out_valid),    32'd1);
                checkVal("bp_stall_data",  32'(out_data),     32'(held_data));
                checkVal("bp_stall_syn",   32'(out_syndrome), 32'(held_syn));
            end
            d         = 4'(sent * 3 + 1);
            out_ready = pattern[cyc % 4];
            in_valid  = (sent < 8);
            in_code   = encode(d);
            in_parity = ^encode(d);
            #1;
            in_hs  = in_valid && in_ready;
            out_hs = out_valid && out_ready;
            if (in_valid && !in_ready) saw_full = 1;
            if (out_hs) begin
                if (exp_q.size() == 0) begin
                    checkVal("bp_extra_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    checkVal("bp_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
                got++;
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            held_syn  = out_syndrome;
            if (in_hs) begin
                exp_q.push_back(d);
                sent++;
            end
            cyc++;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkVal("bp_words_out", 32'(got), 32'd8);
        checkVal("bp_in_ready_fell", 32'(saw_full), 32'd1);
        checkVal("bp_leftover", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        checkVal("bp_no_duplicate", 32'(out_valid), 32'd0);
        checkCounters("bp_cnt");
    endtask

    initial begin
        int lat;
        vecs[0] = '{7'h55, 1'b0, 4'hB, 3'd0, 1'b0, 1'b0};
        vecs[1] = '{7'h45, 1'b0, 4'hB, 3'd5, 1'b1, 1'b0};
        vecs[2] = '{7'h55, 1'b1, 4'hB, 3'd0, 1'b1, 1'b0};
        vecs[3] = '{7'h56, 1'b0, 4'hB, 3'd3, 1'b0, 1'b1};
        vecs[4] = '{7'h00, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0};
        vecs[5] = '{7'h7F, 1'b1, 4'hF, 3'd0, 1'b0, 1'b0};
        vecs[6] = '{7'h54, 1'b0, 4'hB, 3'd1, 1'b1, 1'b0};
        vecs[7] = '{7'h15, 1'b0, 4'hB, 3'd7, 1'b1, 1'b0};
        vecs[8] = '{7'h14, 1'b0, 4'h3, 3'd6, 1'b0, 1'b1};
        vecs[9] = '{7'h7B, 1'b1, 4'hF, 3'd3, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("rst_out_valid", 32'(out_valid), 32'd0);
        checkVal("rst_in_ready",  32'(in_ready),  32'd1);
        checkVal("rst_out_data",  32'(out_data),  32'd0);
        checkVal("rst_syndrome",  32'(out_syndrome), 32'd0);
        checkVal("rst_flags",     32'({out_corrected, out_uncorrectable}), 32'd0);
        checkCounters("rst_cnt");

        for (int i = 0; i < 10; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        runBackpressure();

        // Clear lands on the same edge as a correctable handshake.
        applyStimulus(vecs[1].code, vecs[1].parity, lat);
        checkVal("clr_latency", 32'(lat), 32'd2);
        checkVal("clr_corr_before", 32'(corr_count), 32'(exp_corr));
        cnt_clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cnt_clear = 1'b0;
        exp_corr = 0; exp_unc = 0; exp_corr_s = 0; exp_unc_s = 0;
        checkCounters("clr_cnt");

        for (int i = 0; i < 5; i++) begin
            runVector(vecs[1], $sformatf("sat%0d", i));
        end
        checkVal("sat_corr2_max", 32'(sm_corr_count), 32'd3);
        checkVal("sat_corr16", 32'(corr_count), 32'd5);

        // Fill both stages under backpressure, then reset asynchronously.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = vecs[2].code;
        in_parity = vecs[2].parity;
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkVal("mid_out_valid_before", 32'(out_valid), 32'd1);
        checkVal("mid_in_ready_before",  32'(in_ready),  32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkVal("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkVal("mid_rst_out_data",  32'(out_data),  32'd0);
        checkVal("mid_rst_corr16",    32'(corr_count), 32'd0);
        checkVal("mid_rst_corr2",     32'(sm_corr_count), 32'd0);
        checkVal("mid_rst_flags",     32'({out_corrected, out_uncorrectable}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkVal("mid_rst_no_resurrect", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hamming_74_secded_dec.md
Name: hamming_74_secded_dec

Overview:
- Downstream receive stage for the Hamming(7,4) encoder with overall parity. Consumes the 7-bit code word plus the overall parity bit, which together form a SECDED(8,4) word.
- Computes the syndrome, corrects single-bit errors, detects double-bit errors and emits the 4-bit data word.
- Two-stage registered pipeline with valid/ready handshakes on both sides.
- Saturating correctable and uncorrectable event counters for link-quality monitoring.

Parameters:
- CNT_W, 16, width of each error event counter (>= 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_code  in  7  code word {d3,d2,d1,p4,d0,p2,p1}; bit 0 = position 1 ... bit 6 = position 7.
- in_parity  in  1  overall parity; transmitted XOR of in_code.
- out_valid  out  1  decoded word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  4  decoded data {d3,d2,d1,d0}.
- out_syndrome  out  3  {s4,s2,s1}.
- out_corrected  out  1  a single error was corrected (code or parity bit).
- out_uncorrectable  out  1  a double error was detected.
- cnt_clear  in  1  synchronous clear of both counters.
- corr_count  out  CNT_W  number of corrected words delivered.
- uncorr_count  out  CNT_W  number of uncorrectable words delivered.

Behaviour:
- Reset: all valid flags, out_data, out_syndrome, flags and both counters go to 0; in_ready = 1 after reset.
- Syndrome (stage 1, registered together with the code word):
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
  - pe = (^in_code) ^ in_parity
- Classification (stage 2, registered):
  - syn=0, pe=0: no error. Data taken as is, both flags 0.
  - syn!=0, pe=1: single error at position syn. Flip that code bit, then extract data. out_corrected=1.
  - syn=0, pe=1: the parity bit itself is in error. Data is unchanged. out_corrected=1.
  - syn!=0, pe=0: double error. out_data = uncorrected data bits, out_uncorrectable=1, out_corrected=0.
- Data extraction: d0=c2, d1=c4, d2=c5, d3=c6.
- Latency: 2 cycles from input handshake to out_valid when not stalled. Throughput is 1 word/cycle.
- Handshake:
  - s2_load = !s2_valid | out_ready.
  - s1_load = !s1_valid | s2_load.
  - in_ready = s1_load. This is a combinational path from out_ready, which is permitted.
  - A word is accepted on in_valid & in_ready and delivered on out_valid & out_ready.
  - While out_valid=1 and out_ready=0, all out_* signals stay stable.
  - When stage 1 holds a word and stage 2 is stalled, in_ready=0.
  - No word is dropped or duplicated.
  - A bubble in stage 1 may be filled while stage 2 is stalled.
- Counters:
  - Increment on each output handshake carrying the matching flag. Updates are registered; the count is visible the cycle after the handshake.
  - Saturate at 2^CNT_W-1 and never wrap.
  - cnt_clear wins over a simultaneous increment: the result is 0.
- Reset mid-operation: words in flight are discarded; outputs return to reset values immediately (asynchronous).

Test Plan:
- Clean word: in_code=7'h55, in_parity=0 (data 4'b1011), out_ready=1 -> 2 cycles later out_data=4'b1011, syndrome 0, flags 0, counters unchanged.
- Single data error: in_code=7'b1000101, parity 0 -> out_data=4'b1011, out_syndrome=3'd5, out_corrected=1, corr_count +1.
- Parity-bit error: in_code=7'h55, in_parity=1 -> out_data=4'b1011, syndrome 0, out_corrected=1.
- Double error: in_code=7'b1010110, parity 0 -> out_syndrome=3'd3, out_uncorrectable=1, out_corrected=0, uncorr_count +1.
- Backpressure: stream 8 words with out_ready toggling 1-0-0-1 -> in_ready falls once both stages are full, outputs stay stable while stalled, all 8 words come out in order with no loss or duplication.
- Counter edge cases:
  - Set CNT_W=2 and send 5 correctable words -> corr_count saturates at 3.
  - Assert cnt_clear on the same cycle as a correctable handshake -> corr_count=0.
  - Assert rst mid-stream -> out_valid=0 immediately and counters=0.
